serial_adder: RTL
=================

# serial_adder

Parametrised multi-cycle adder that computes `sum = a + b + cin` over `WIDTH` bits, processing `DIGIT` bits per clock through one registered carry. It is the sequential successor to the single-bit full adder and trades latency for area when wide operands arrive at a low rate. A start/busy/done handshake lets a controller or testbench issue one addition at a time and collect a held result.

## Interface
- `WIDTH`, 8: operand and result width in bits; must be ≥1.
- `DIGIT`, 1: bits added per cycle; must divide `WIDTH`. `STEPS = WIDTH/DIGIT`.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request a new addition; sampled only in IDLE.
- `a`  in  WIDTH  operand A; captured on the accepting edge.
- `b`  in  WIDTH  operand B; captured on the accepting edge.
- `cin`  in  1  carry-in; captured on the accepting edge.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse when a result is ready.
- `sum`  out  WIDTH  result; registered and held.
- `cout`  out  1  carry-out; registered and held.

## Operation
- **States:**
  - IDLE: `start`=1 goes to RUN. `a`, `b` and `cin` are loaded into the shift/carry registers and the digit counter is cleared.
  - RUN: each cycle adds the low `DIGIT` bits of the A and B shift registers plus the carry register. The result digit is shifted into the top of the sum shift register, the operand registers shift right by `DIGIT`, the new carry is stored and the counter increments. After the cycle with counter = `STEPS-1`, goes to DONE.
  - DONE: goes to IDLE unconditionally after one cycle.
- **Output registers:** `sum` and `cout` load the completed result on the RUN→DONE edge. They hold that value until the next RUN→DONE edge, and are not disturbed while a later operation runs.
- **Arithmetic:** unsigned, modulo 2^`WIDTH`. `cout` is bit `WIDTH` of the true sum.
- **Start handling:** `start` is ignored in RUN and DONE; no queueing. `start` held high continuously gives back-to-back operations.
- **Operand stability:** changes to `a`, `b` or `cin` after the accepting edge have no effect.
- **Reset values:** `rst` asserted at any time, including mid-RUN, returns the block to IDLE and clears everything. `busy`=0, `done`=0, `sum`=0, `cout`=0, and the counter, shift registers and carry register are all 0. The aborted operation produces no `done`.
- **Degenerate case:** `WIDTH=1`, `DIGIT=1` behaves as a registered full adder.

## Timing
- Accepting edge E0: IDLE with `start`=1. `busy` rises after E0.
- RUN edges E1…E`STEPS` each process one digit.
- After E`STEPS`: `done`=1 and `sum`/`cout` are valid, for exactly one cycle.
- After E`STEPS`+1: IDLE, `busy`=0, `done`=0.
- Latency from the accepting edge to `done` is `STEPS` cycles. Minimum issue interval is `STEPS`+2 cycles.
- `done` and the `sum`/`cout` update occur in the same cycle, so a consumer may sample `sum` whenever `done`=1.

## Structure
- **Shared package/header:**
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the `STEPS` derivation;
  - the counter-width function `clog2(STEPS)`, minimum 1.
- **Sub-module:** one, `digit_adder`, a parametrised `DIGIT`-bit combinational ripple of full-adder slices with ports (`x`, `y`, `ci`, `s`, `co`). The top level holds the FSM, counter, shift registers, carry register and output registers.
- **Elaboration checks:** elaboration must fail when `WIDTH % DIGIT != 0`.

## Test plan
- **Exhaustive, WIDTH=1, DIGIT=1:** all 8 `a`/`b`/`cin` combinations -> matches the full-adder truth table, e.g. 1+1+1 gives `sum`=1, `cout`=1. `done` comes 1 cycle after acceptance.
- **Carry ripple, WIDTH=8, DIGIT=1:** `a`=8'hFF, `b`=8'h01, `cin`=0 -> `sum`=8'h00, `cout`=1. `done` comes exactly 8 cycles after the accepting edge and `busy` is high for 9 cycles. Then `a`=8'h5A, `b`=8'h25, `cin`=1 -> `sum`=8'h80, `cout`=0.
- **Wider digits, WIDTH=8, DIGIT=4:** `a`=8'hF0, `b`=8'h1F, `cin`=1 -> `sum`=8'h10, `cout`=1, with `done` after 2 cycles. Also run randomized operands against a reference model at DIGIT=2 and DIGIT=8.
- **Ignored inputs:** pulse `start` in RUN and DONE, and change `a`/`b` mid-RUN -> no extra `done`, and the result reflects the captured operands. The previous `sum` stays stable throughout RUN.
- **Reset mid-operation:** assert `rst` asynchronously at RUN digit 3 of 8 -> all outputs 0 immediately, no `done`. A new `start` after release completes normally.
- **Back-to-back:** hold `start` high for 3 operations -> `done` pulses spaced `STEPS`+2 cycles apart, each with the correct `sum` and `cout`.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding and
// elaboration-time sizing helpers.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of digit cycles needed to cover the full operand width.
    function automatic int calc_steps(input int width, input int digit);
        return width / digit;
    endfunction

    // Width of a counter that can hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// DIGIT-bit combinational ripple-carry adder built from full-adder slices.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_slice
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co = c[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: sums a + b + cin over WIDTH bits, DIGIT bits per clock,
// through one registered carry, with a start/busy/done handshake.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int STEPS = calc_steps(WIDTH, DIGIT);
    localparam int CW    = cnt_width(STEPS);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic [DIGIT-1:0] dig_s;
    logic             dig_co;

    digit_adder #(
        .DIGIT(DIGIT)
    ) u_digit_adder (
        .x (opa_q[DIGIT-1:0]),
        .y (opb_q[DIGIT-1:0]),
        .ci(carry_q),
        .s (dig_s),
        .co(dig_co)
    );

    // NOTE: every _d gets its hold value first, so no path leaves a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    opa_d   = a;
                    opb_d   = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            RUN: begin
                // New digit enters at the top; after STEPS shifts it is aligned.
                acc_d   = WIDTH'({dig_s, acc_q} >> DIGIT);
                opa_d   = opa_q >> DIGIT;
                opb_d   = opb_q >> DIGIT;
                carry_d = dig_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    sum_d   = acc_d;
                    cout_d  = dig_co;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments; all of it clears on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
